// File: rtl/dct_out_transpose_buf_if.sv
// Streaming bundle between the DCT column pass, the transpose buffer
// and the write DMA: column input stream plus row output stream.
interface dct_out_transpose_buf_if #(
    parameter int COEF_WIDTH = 16,
    parameter int DATA_WIDTH = 64
);
    logic                    s_valid;
    logic                    s_ready;
    logic [4*COEF_WIDTH-1:0] s_data;
    logic                    wr_en;
    logic                    full_n;
    logic [DATA_WIDTH-1:0]   dout;

    modport master (
        output s_valid,
        output s_data,
        output full_n,
        input  s_ready,
        input  wr_en,
        input  dout
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  full_n,
        output s_ready,
        output wr_en,
        output dout
    );
endinterface

// File: rtl/dct_out_transpose_buf.sv
// Ping-pong 4x4 transpose buffer: captures coefficient columns from the
// DCT column pass and streams row-major 64-bit words to the write DMA.
module dct_out_transpose_buf #(
    parameter int COEF_WIDTH              = 16,
    parameter int C_M_AXI_GMEM_DATA_WIDTH = 64,
    parameter int BLK_CNT_WIDTH           = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     clear,
    dct_out_transpose_buf_if.slave   bus,
    output logic                     idle,
    output logic [BLK_CNT_WIDTH-1:0] blk_cnt
);
    localparam int DW = C_M_AXI_GMEM_DATA_WIDTH;

    if (DW != 4 * COEF_WIDTH) begin : g_bad_width
        $error("dct_out_transpose_buf: data width must be 4*COEF_WIDTH");
    end

    logic [DW-1:0] mem_q [2][4];

    logic [1:0]               full_q, full_d;
    logic                     wr_bank_q, wr_bank_d;
    logic                     rd_bank_q, rd_bank_d;
    logic [1:0]               wr_col_q, wr_col_d;
    logic [1:0]               rd_row_q, rd_row_d;
    logic [BLK_CNT_WIDTH-1:0] blk_cnt_q, blk_cnt_d;
    logic                     in_hs, out_hs;

    assign in_hs  = bus.s_valid & ~full_q[wr_bank_q];
    assign out_hs = full_q[rd_bank_q] & bus.full_n;

    // Outputs come only from registered state; full_n never reaches them.
    assign bus.s_ready = ~full_q[wr_bank_q];
    assign bus.wr_en   = full_q[rd_bank_q];
    assign bus.dout    = full_q[rd_bank_q] ? mem_q[rd_bank_q][rd_row_q] : '0;

    assign idle    = ~full_q[0] & ~full_q[1] & (wr_col_q == 2'd0);
    assign blk_cnt = blk_cnt_q;

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_col_d  = wr_col_q;
        rd_row_d  = rd_row_q;
        blk_cnt_d = blk_cnt_q;
        if (in_hs) begin
            wr_col_d = wr_col_q + 2'd1;
            if (wr_col_q == 2'd3) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        // Read and write banks always differ here, so both updates apply.
        if (out_hs) begin
            rd_row_d = rd_row_q + 2'd1;
            if (rd_row_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                blk_cnt_d         = blk_cnt_q + BLK_CNT_WIDTH'(1);
            end
        end
        if (clear) begin
            full_d    = 2'b00;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_col_d  = 2'd0;
            rd_row_d  = 2'd0;
            blk_cnt_d = '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_col_q  <= 2'd0;
            rd_row_q  <= 2'd0;
            blk_cnt_q <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_col_q  <= wr_col_d;
            rd_row_q  <= rd_row_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Column element i lands in row i; storage is kept row-major.
    always_ff @(posedge ap_clk) begin
        if (in_hs && !clear) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (wr_col_q == 2'(j)) begin
                        mem_q[wr_bank_q][2'(i)][j*COEF_WIDTH +: COEF_WIDTH] <=
                            bus.s_data[i*COEF_WIDTH +: COEF_WIDTH];
                    end
                end
            end
        end
    end
endmodule

// File: doc/dct_out_transpose_buf.md
Name: dct_out_transpose_buf

Overview:
- Output stage of the 4x4 2D DCT core, directly upstream of the write DMA.
- Accepts coefficient blocks column by column from the column-pass datapath and holds them in a ping-pong pair of 4x4 register banks.
- Emits each block row by row (row-major) as 64-bit words on the DMA's wr_en/full_n/din streaming interface, so memory receives the transposed result.

Parameters:
- COEF_WIDTH, 16, width of one signed coefficient.
- C_M_AXI_GMEM_DATA_WIDTH, 64, output word width; must equal 4*COEF_WIDTH (elaboration error otherwise).
- BLK_CNT_WIDTH, 16, width of the drained-block counter.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush, one-cycle pulse (driven from the ap_start rising edge).
- s_valid  in  1  input column valid.
- s_ready  out  1  input column ready.
- s_data  in  4*COEF_WIDTH  one column; element row i at bits [COEF_WIDTH*i +: COEF_WIDTH].
- wr_en  out  1  output word valid (to DMA wr_en).
- full_n  in  1  output ready (from DMA full_n).
- dout  out  C_M_AXI_GMEM_DATA_WIDTH  output row word (to DMA din).
- idle  out  1  no data held or partially captured.
- blk_cnt  out  BLK_CNT_WIDTH  number of blocks fully drained since reset/clear.

Behaviour:
- Reset: asynchronous, active-low; all registers are cleared.
  - Reset values: s_ready=1, wr_en=0, dout=0, idle=1, blk_cnt=0; both banks empty; wr_bank=rd_bank=0; wr_col=rd_row=0.
  - Bank contents need not be reset.
- Handshakes: in_hs = s_valid & s_ready; out_hs = wr_en & full_n.
- Write side (bank[wr_bank]):
  - s_ready = ~full[wr_bank], combinational from registered state.
  - On in_hs, s_data is written to column wr_col, i.e. M[i][wr_col] = element i; then wr_col increments.
  - On in_hs with wr_col==3: set full[wr_bank], toggle wr_bank, reset wr_col to 0.
- Read side (bank[rd_bank]):
  - wr_en = full[rd_bank].
  - dout = row rd_row of bank[rd_bank]: M[r][j] at bits [COEF_WIDTH*j +: COEF_WIDTH].
  - dout is 0 when wr_en=0.
  - dout is a mux of registered storage; no combinational path from full_n to dout or wr_en.
  - On out_hs, rd_row increments.
  - On out_hs with rd_row==3: clear full[rd_bank], toggle rd_bank, reset rd_row to 0, blk_cnt += 1 (wraps modulo 2^BLK_CNT_WIDTH).
- Hold rule: while wr_en=1 and full_n=0, wr_en and dout stay stable (AXI WVALID rule).
- Latency: the first row is valid on the cycle after the edge that captures column 3.
- Throughput:
  - Full rate both sides; ping-pong allows continuous streaming at 4 words in / 4 words out per block with no bubbles.
  - When both banks are full, s_ready=0 until the read side frees a bank.
  - A bank freed by out_hs on edge N is writable at cycle N+1 (s_ready rises the cycle after the last row is accepted; no same-cycle bypass).
- Simultaneous events:
  - in_hs and out_hs in the same cycle always target different banks; both take effect.
  - full[] set and clear on the same edge apply to different indices.
- Partial block: fewer than 4 columns never asserts wr_en; data waits indefinitely.
- clear:
  - Same effect as reset except bank contents.
  - Takes priority over in_hs/out_hs in the same cycle: those handshakes are discarded, pointers are zeroed, blk_cnt=0.
- idle = ~full[0] & ~full[1] & (wr_col==0).
- Values: coefficients pass through bit-exact with no arithmetic; sign is irrelevant.

Test Plan:
- Single block, full_n=1:
  - Stimulus: columns C0..C3 with element i of column j = 16'h(10*i+j), e.g. C1 = {16'h0031,16'h0021,16'h0011,16'h0001}.
  - Required: wr_en rises the cycle after C3; 4 consecutive words; row1 = {16'h0013,16'h0012,16'h0011,16'h0010}; then blk_cnt=1, idle=1.
- Back-to-back, s_valid=1 and full_n=1 for 3 blocks (12 columns):
  - Required: s_ready never drops; 12 output words with no gaps after the first; blk_cnt=3.
- Output backpressure, full_n=0 for 20 cycles during row 2:
  - Required: wr_en and dout held stable; 8 columns are accepted, then s_ready=0; after full_n returns, rows resume in order with no loss or duplication.
- Random s_valid/full_n toggling (50% each) over 100 blocks with a scoreboard:
  - Required: all outputs equal the transpose of the inputs; blk_cnt=100.
- clear asserted after 2 columns of block 1, with block 0 pending output:
  - Required: the next cycle shows wr_en=0, idle=1, blk_cnt=0; a fresh block afterwards transposes correctly.
- ap_rst_n asserted asynchronously mid-drain (between edges):
  - Required: wr_en=0 and s_ready=1 immediately, without waiting for a clock; normal operation after release.
